// File: rtl/perf_pkg.sv
// Shared definitions for the pipeline performance counter block.
//   - default NSTAGE / CNT_W values
//   - dump FSM state enum
//   - record struct presented on the rec_* interface
package perf_pkg;

    localparam int unsigned NSTAGE_DEF = 8;
    localparam int unsigned CNT_W_DEF  = 32;
    // Record count fields are sized for the widest supported counter (CNT_W <= 64).
    localparam int unsigned CNT_W_MAX  = 64;
    localparam int unsigned ID_W       = 8;

    typedef enum logic [0:0] {
        StIdle,
        StEmit
    } perf_state_e;

    typedef struct packed {
        logic [ID_W-1:0]      id;
        logic [CNT_W_MAX-1:0] busy;
        logic [CNT_W_MAX-1:0] stall;
        logic [CNT_W_MAX-1:0] bubble;
        logic                 sat;
    } perf_rec_t;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter with sticky saturation flag.
// Ports:
//   clk, rst    - clock, synchronous active-low reset
//   clr_i       - clear count and flag at this edge (takes priority over inc_i)
//   inc_i       - count one event this cycle
//   cnt_next_o  - count including this cycle's event (the value a snapshot must capture)
//   sat_next_o  - sticky flag including this cycle's saturation attempt
module perf_sat_counter
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             sat_next_o
);

    logic [CNT_W-1:0] cnt_q;
    logic             sat_q;
    logic             at_max;

    assign at_max     = &cnt_q;
    assign cnt_next_o = (inc_i && !at_max) ? cnt_q + CNT_W'(1) : cnt_q;
    // Flag sets on an increment attempt while already at the ceiling.
    assign sat_next_o = sat_q | (inc_i & at_max);

    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_next_o;
            sat_q <= sat_next_o;
        end
    end

endmodule

// File: rtl/perf_pipe_counter.sv
// Per-stage pipeline occupancy counters (busy / stall / bubble) with snapshot-and-dump.
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   stage_valid, stage_stall      - per-stage status sampled every cycle
//   dump_req                      - request a snapshot and a sweep of records
//   rec_valid / rec_ready         - record handshake
//   rec_id, rec_busy, rec_stall,
//   rec_bubble, rec_sat           - current record (stage id, snapshot counts, sat flag)
//   dump_busy                     - high while records are being emitted
module perf_pipe_counter
    import perf_pkg::*;
#(
    parameter int unsigned NSTAGE = NSTAGE_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stage_valid,
    input  logic [NSTAGE-1:0] stage_stall,
    input  logic              dump_req,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [ID_W-1:0]   rec_id,
    output logic [CNT_W-1:0]  rec_busy,
    output logic [CNT_W-1:0]  rec_stall,
    output logic [CNT_W-1:0]  rec_bubble,
    output logic              rec_sat,
    output logic              dump_busy
);

    localparam int unsigned    IDX_W    = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSTAGE - 1);

    perf_state_e      state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             snap_load;

    // Live counters
    logic [NSTAGE-1:0] inc_busy, inc_stall, inc_bub;
    logic [NSTAGE-1:0] sat_b, sat_s, sat_u;
    logic [CNT_W-1:0]  nxt_busy   [NSTAGE];
    logic [CNT_W-1:0]  nxt_stall  [NSTAGE];
    logic [CNT_W-1:0]  nxt_bubble [NSTAGE];

    // Exactly one class per stage per cycle; stall is irrelevant without valid.
    assign inc_busy  = stage_valid & ~stage_stall;
    assign inc_stall = stage_valid & stage_stall;
    assign inc_bub   = ~stage_valid;

    for (genvar i = 0; i < int'(NSTAGE); i++) begin : g_stage
        perf_sat_counter #(.CNT_W(CNT_W)) u_busy (
            .clk        (clk),
            .rst        (rst),
            .clr_i      (snap_load),
            .inc_i      (inc_busy[i]),
            .cnt_next_o (nxt_busy[i]),
            .sat_next_o (sat_b[i])
        );
        perf_sat_counter #(.CNT_W(CNT_W)) u_stall (
            .clk        (clk),
            .rst        (rst),
            .clr_i      (snap_load),
            .inc_i      (inc_stall[i]),
            .cnt_next_o (nxt_stall[i]),
            .sat_next_o (sat_s[i])
        );
        perf_sat_counter #(.CNT_W(CNT_W)) u_bubble (
            .clk        (clk),
            .rst        (rst),
            .clr_i      (snap_load),
            .inc_i      (inc_bub[i]),
            .cnt_next_o (nxt_bubble[i]),
            .sat_next_o (sat_u[i])
        );
    end

    // Snapshot registers
    logic [CNT_W-1:0]  snap_busy_q   [NSTAGE];
    logic [CNT_W-1:0]  snap_stall_q  [NSTAGE];
    logic [CNT_W-1:0]  snap_bubble_q [NSTAGE];
    logic [NSTAGE-1:0] snap_sat_q;

    // Snapshot captures the cycle's own sample while the live counters clear on the same edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(NSTAGE); i++) begin
                snap_busy_q[i]   <= '0;
                snap_stall_q[i]  <= '0;
                snap_bubble_q[i] <= '0;
            end
            snap_sat_q <= '0;
        end else if (snap_load) begin
            for (int i = 0; i < int'(NSTAGE); i++) begin
                snap_busy_q[i]   <= nxt_busy[i];
                snap_stall_q[i]  <= nxt_stall[i];
                snap_bubble_q[i] <= nxt_bubble[i];
            end
            snap_sat_q <= sat_b | sat_s | sat_u;
        end
    end

    // Dump FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        snap_load = 1'b0;
        rec_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (dump_req) begin
                    snap_load = 1'b1;
                    state_d   = StEmit;
                    idx_d     = '0;
                end
            end
            StEmit: begin
                rec_valid = 1'b1;
                // Requests during a sweep merge into one pending re-dump; a request in
                // the final-transfer cycle itself is honoured the same way.
                pend_d    = pend_q | dump_req;
                if (rec_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d  = '0;
                        pend_d = 1'b0;
                        if (pend_q || dump_req) begin
                            snap_load = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dump_busy = (state_q == StEmit);

    // Record assembly
    perf_rec_t rec;
    logic      unused_rec;

    always_comb begin
        rec        = '0;
        rec.id     = ID_W'(idx_q);
        rec.busy   = CNT_W_MAX'(snap_busy_q[idx_q]);
        rec.stall  = CNT_W_MAX'(snap_stall_q[idx_q]);
        rec.bubble = CNT_W_MAX'(snap_bubble_q[idx_q]);
        rec.sat    = snap_sat_q[idx_q];
    end

    assign rec_id     = rec.id;
    assign rec_busy   = rec.busy[CNT_W-1:0];
    assign rec_stall  = rec.stall[CNT_W-1:0];
    assign rec_bubble = rec.bubble[CNT_W-1:0];
    assign rec_sat    = rec.sat;
    // Upper struct bits beyond CNT_W are always zero.
    assign unused_rec = ^{rec.busy, rec.stall, rec.bubble};

endmodule

// File: tb/tb_perf_pipe_counter.sv
// Self-checking bench: two DUTs (16-bit and 4-bit counters) share stimulus and are
// compared every cycle against a queue-based record model with unbounded counts.
module tb_perf_pipe_counter;

    localparam int MAXB = 65535;
    localparam int MAXS = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] valid, stall;
    logic       dump, ready;

    logic        rec_valid_b, dump_busy_b, rec_sat_b;
    logic [7:0]  rec_id_b;
    logic [15:0] rec_busy_b, rec_stall_b, rec_bubble_b;
    logic        rec_valid_s, dump_busy_s, rec_sat_s;
    logic [7:0]  rec_id_s;
    logic [3:0]  rec_busy_s, rec_stall_s, rec_bubble_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    perf_pipe_counter #(.NSTAGE(4), .CNT_W(16)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .stage_valid (valid),
        .stage_stall (stall),
        .dump_req    (dump),
        .rec_valid   (rec_valid_b),
        .rec_ready   (ready),
        .rec_id      (rec_id_b),
        .rec_busy    (rec_busy_b),
        .rec_stall   (rec_stall_b),
        .rec_bubble  (rec_bubble_b),
        .rec_sat     (rec_sat_b),
        .dump_busy   (dump_busy_b)
    );

    perf_pipe_counter #(.NSTAGE(4), .CNT_W(4)) dut_s (
        .clk         (clk),
        .rst         (rst),
        .stage_valid (valid),
        .stage_stall (stall),
        .dump_req    (dump),
        .rec_valid   (rec_valid_s),
        .rec_ready   (ready),
        .rec_id      (rec_id_s),
        .rec_busy    (rec_busy_s),
        .rec_stall   (rec_stall_s),
        .rec_bubble  (rec_bubble_s),
        .rec_sat     (rec_sat_s),
        .dump_busy   (dump_busy_s)
    );

    // Reference model: unbounded live counts, queue of pending records.
    typedef struct {
        int id;
        int b;
        int s;
        int u;
    } rec_t;

    int   live_b[4], live_s[4], live_u[4];
    bit   pend;
    rec_t q[$];

    function automatic int cap(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic logic [58:0] exp_v(input int m);
        rec_t r;
        logic sat;
        if (q.size() == 0) return '0;
        r   = q[0];
        sat = (r.b > m) || (r.s > m) || (r.u > m);
        return {2'b11, 8'(r.id), 16'(cap(r.b, m)), 16'(cap(r.s, m)), 16'(cap(r.u, m)), sat};
    endfunction

    function automatic logic [58:0] act_b();
        return {rec_valid_b, dump_busy_b,
                rec_valid_b ? {rec_id_b, rec_busy_b, rec_stall_b, rec_bubble_b, rec_sat_b}
                            : 57'd0};
    endfunction

    function automatic logic [58:0] act_s();
        return {rec_valid_s, dump_busy_s,
                rec_valid_s ? {rec_id_s, 12'd0, rec_busy_s, 12'd0, rec_stall_s,
                               12'd0, rec_bubble_s, rec_sat_s} : 57'd0};
    endfunction

    // Advance the model by one clock using the current inputs, then clock the DUTs.
    task automatic step();
        bit was_emit;
        bit snap;
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                live_b[i] = 0; live_s[i] = 0; live_u[i] = 0;
            end
            pend = 0;
            q.delete();
        end else begin
            was_emit = (q.size() > 0);
            snap     = 0;
            for (int i = 0; i < 4; i++) begin
                if (!valid[i])     live_u[i]++;
                else if (stall[i]) live_s[i]++;
                else               live_b[i]++;
            end
            if (!was_emit && dump) snap = 1;
            if (was_emit && dump)  pend = 1;
            if (was_emit && ready) begin
                void'(q.pop_front());
                if (q.size() == 0 && pend) begin
                    snap = 1;
                    pend = 0;
                end
            end
            if (snap) begin
                for (int i = 0; i < 4; i++) begin
                    q.push_back('{id: i, b: live_b[i], s: live_s[i], u: live_u[i]});
                    live_b[i] = 0; live_s[i] = 0; live_u[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_in();
        valid = 4'($urandom);
        stall = 4'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0; valid = '1; stall = '0; dump = 1'b1; ready = 1'b1;
        step();
        step();
        total++;
        if ({rec_valid_b, dump_busy_b, rec_valid_s, dump_busy_s} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle got=%b want=0000",
                     {rec_valid_b, dump_busy_b, rec_valid_s, dump_busy_s});
        end
        rst = 1'b1; dump = 1'b0; valid = '0;
        step();
        total++;
        if (act_b() !== exp_v(MAXB)) begin
            bad++; $display("FAIL reset_release got=%h want=%h", act_b(), exp_v(MAXB));
        end
    endtask

    task automatic test_basic();
        rst = 1'b0; dump = 1'b0; ready = 1'b1; valid = '0; stall = '0;
        step();
        rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            rnd_in();
            valid[2] = (c < 10);
            stall[2] = (c < 3);
            dump     = (c == 14);
            total++;
            if (act_b() !== exp_v(MAXB)) begin
                bad++; $display("FAIL basic_count got=%h want=%h", act_b(), exp_v(MAXB));
            end
            step();
        end
        dump = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rnd_in();
            total++;
            if (rec_valid_b !== 1'b1 || rec_id_b !== 8'(k)) begin
                bad++; $display("FAIL basic_order got=%b/%0d want=1/%0d", rec_valid_b, rec_id_b, k);
            end
            if (k == 2) begin
                total++;
                if ({rec_busy_b, rec_stall_b, rec_bubble_b} !== {16'd7, 16'd3, 16'd5}) begin
                    bad++;
                    $display("FAIL basic_id2 got=%0d/%0d/%0d want=7/3/5",
                             rec_busy_b, rec_stall_b, rec_bubble_b);
                end
            end
            total++;
            if (act_s() !== exp_v(MAXS)) begin
                bad++; $display("FAIL basic_small got=%h want=%h", act_s(), exp_v(MAXS));
            end
            step();
        end
        total++;
        if (rec_valid_b !== 1'b0 || dump_busy_b !== 1'b0) begin
            bad++; $display("FAIL basic_done got=%b%b want=00", rec_valid_b, dump_busy_b);
        end
    endtask

    task automatic test_backpressure();
        ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rnd_in();
            dump = (c == 9);
            total++;
            if (act_b() !== exp_v(MAXB)) begin
                bad++; $display("FAIL bp_count got=%h want=%h", act_b(), exp_v(MAXB));
            end
            step();
        end
        dump = 1'b0;
        step();
        ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            rnd_in();
            total++;
            if (rec_valid_b !== 1'b1 || rec_id_b !== 8'd1) begin
                bad++; $display("FAIL bp_hold got=%b/%0d want=1/1", rec_valid_b, rec_id_b);
            end
            total++;
            if (act_b() !== exp_v(MAXB)) begin
                bad++; $display("FAIL bp_hold_rec got=%h want=%h", act_b(), exp_v(MAXB));
            end
            total++;
            if (act_s() !== exp_v(MAXS)) begin
                bad++; $display("FAIL bp_hold_small got=%h want=%h", act_s(), exp_v(MAXS));
            end
            step();
        end
        ready = 1'b1;
        step();
        total++;
        if (rec_valid_b !== 1'b1 || rec_id_b !== 8'd2) begin
            bad++; $display("FAIL bp_next got=%b/%0d want=1/2", rec_valid_b, rec_id_b);
        end
        step();
        step();
        total++;
        if (act_b() !== exp_v(MAXB)) begin
            bad++; $display("FAIL bp_drain got=%h want=%h", act_b(), exp_v(MAXB));
        end
    endtask

    task automatic test_saturation();
        rst = 1'b0; ready = 1'b1; dump = 1'b0;
        step();
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            rnd_in();
            valid[0] = 1'b1;
            stall[0] = 1'b0;
            dump     = (c == 19);
            step();
        end
        dump = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rnd_in();
            valid[0] = 1'b1;
            stall[0] = 1'b0;
            if (k == 0) begin
                total++;
                if ({rec_id_s, rec_busy_s, rec_sat_s} !== {8'd0, 4'd15, 1'b1}) begin
                    bad++;
                    $display("FAIL sat_first got=%0d/%0d/%b want=0/15/1",
                             rec_id_s, rec_busy_s, rec_sat_s);
                end
            end
            total++;
            if (act_s() !== exp_v(MAXS)) begin
                bad++; $display("FAIL sat_small got=%h want=%h", act_s(), exp_v(MAXS));
            end
            step();
        end
        for (int c = 0; c < 3; c++) begin
            rnd_in();
            valid[0] = 1'b1;
            stall[0] = 1'b0;
            dump     = (c == 2);
            step();
        end
        dump = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rnd_in();
            if (k == 0) begin
                total++;
                if ({rec_id_s, rec_busy_s, rec_sat_s} !== {8'd0, 4'd7, 1'b0}) begin
                    bad++;
                    $display("FAIL sat_second got=%0d/%0d/%b want=0/7/0",
                             rec_id_s, rec_busy_s, rec_sat_s);
                end
            end
            total++;
            if (act_s() !== exp_v(MAXS)) begin
                bad++; $display("FAIL sat_small2 got=%h want=%h", act_s(), exp_v(MAXS));
            end
            step();
        end
    endtask

    task automatic test_pending();
        int n = 0;
        ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            rnd_in();
            dump = (c == 0) || (c == 1) || (c == 3);
            if (rec_valid_b && ready) begin
                total++;
                if (rec_id_b !== 8'(n % 4)) begin
                    bad++; $display("FAIL pend_order got=%0d want=%0d", rec_id_b, n % 4);
                end
                n++;
            end
            total++;
            if (act_b() !== exp_v(MAXB)) begin
                bad++; $display("FAIL pend_rec got=%h want=%h", act_b(), exp_v(MAXB));
            end
            step();
        end
        dump = 1'b0;
        total++;
        if (n !== 8) begin
            bad++; $display("FAIL pend_sweeps got=%0d records want=8", n);
        end
    endtask

    task automatic test_reset_mid();
        ready = 1'b1; dump = 1'b1;
        rnd_in();
        step();
        dump = 1'b0;
        step();
        total++;
        if (rec_valid_b !== 1'b1 || rec_id_b !== 8'd1) begin
            bad++; $display("FAIL rmid_at1 got=%b/%0d want=1/1", rec_valid_b, rec_id_b);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        total++;
        if ({rec_valid_b, dump_busy_b} !== 2'b00) begin
            bad++; $display("FAIL rmid_drop got=%b%b want=00", rec_valid_b, dump_busy_b);
        end
        // Snapshot taken in the same cycle stage 3 is valid includes that cycle.
        valid = 4'b1000; stall = 4'b0000; dump = 1'b1;
        step();
        valid = '0; dump = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                total++;
                if ({rec_busy_b, rec_stall_b, rec_bubble_b} !== {16'd1, 16'd0, 16'd0}) begin
                    bad++;
                    $display("FAIL edge_first got=%0d/%0d/%0d want=1/0/0",
                             rec_busy_b, rec_stall_b, rec_bubble_b);
                end
            end
            step();
        end
        dump = 1'b1;
        step();
        dump = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                total++;
                if ({rec_busy_b, rec_stall_b, rec_bubble_b} !== {16'd0, 16'd0, 16'd5}) begin
                    bad++;
                    $display("FAIL edge_next got=%0d/%0d/%0d want=0/0/5",
                             rec_busy_b, rec_stall_b, rec_bubble_b);
                end
            end
            total++;
            if (act_b() !== exp_v(MAXB)) begin
                bad++; $display("FAIL edge_rec got=%h want=%h", act_b(), exp_v(MAXB));
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 199) != 0);
            rnd_in();
            dump  = ($urandom_range(0, 15) == 0);
            ready = ($urandom_range(0, 9) < 7);
            total++;
            if (act_b() !== exp_v(MAXB)) begin
                bad++; $display("FAIL rand_big c=%0d got=%h want=%h", c, act_b(), exp_v(MAXB));
            end
            total++;
            if (act_s() !== exp_v(MAXS)) begin
                bad++; $display("FAIL rand_small c=%0d got=%h want=%h", c, act_s(), exp_v(MAXS));
            end
            step();
        end
        rst = 1'b1; dump = 1'b0; ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            rnd_in();
            total++;
            if (act_b() !== exp_v(MAXB)) begin
                bad++; $display("FAIL drain_big got=%h want=%h", act_b(), exp_v(MAXB));
            end
            total++;
            if (act_s() !== exp_v(MAXS)) begin
                bad++; $display("FAIL drain_small got=%h want=%h", act_s(), exp_v(MAXS));
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_pending();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
